// File: rtl/cache_feeder_pkg.sv
// Shared types and op decoding for the cache trace feeder.
package cache_feeder_pkg;

    localparam int         ADDR_W   = 48;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } feeder_state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/cache_feeder_fifo.sv
// Synchronous FIFO holding {addr, op} trace entries; head is read combinationally.
module cache_feeder_fifo #(
    parameter int DW    = 56,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cache_trace_feeder.sv
// Buffers trace beats and issues back-pressure-safe read/write requests to cache_top.
// Define CACHE_FEEDER_STATS_EN to build the issued/illegal statistics counters.
module cache_trace_feeder #(
    parameter int ADDR_W = cache_feeder_pkg::ADDR_W,
    parameter int OP_W   = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trc_valid,
    output logic              trc_ready,
    input  logic [ADDR_W-1:0] trc_addr,
    input  logic [OP_W-1:0]   trc_op,
    input  logic              trc_last,
    output logic              cache_req_valid,
    input  logic              cache_req_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [OP_W-1:0]   cache_op,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);

    import cache_feeder_pkg::*;

    localparam int DW = ADDR_W + OP_W;

    feeder_state_t     state;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DW-1:0]     head;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic              consume;
    logic              out_vld;
    logic [ADDR_W-1:0] out_addr;
    logic [OP_W-1:0]   out_op;

    // Ready comes only from registered state, never from cache_req_ready.
    assign trc_ready = reset && !fifo_full && (state == IDLE || state == RUN);
    assign accept    = trc_valid && trc_ready;
    assign legal     = is_legal_op(trc_op);
    assign push      = accept && legal;
    assign consume   = out_vld && cache_req_ready;
    assign pop       = !fifo_empty && (!out_vld || consume);

    cache_feeder_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({trc_addr, trc_op}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register refills in the consuming cycle, giving one request per clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_op   <= '0;
        end else if (pop) begin
            out_vld  <= 1'b1;
            out_addr <= head[DW-1:OP_W];
            out_op   <= head[OP_W-1:0];
        end else if (consume) begin
            out_vld  <= 1'b0;
        end
    end

    assign cache_req_valid = out_vld;
    assign cache_addr      = out_addr;
    assign cache_op        = out_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= trc_last ? DRAIN : RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && trc_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && !out_vld) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_FEEDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else begin
            if (consume && issued_cnt != CNT_MAX)
                issued_cnt <= issued_cnt + CNT_W'(1);
            if (accept && !legal && illegal_cnt != CNT_MAX)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end
`else
    assign issued_cnt  = '0;
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_trace_feeder.sv
// Directed bench for cache_trace_feeder with a request scoreboard queue.
module tb_cache_trace_feeder;

    localparam int ADDR_W = 48;
    localparam int OP_W   = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OP_W-1:0]   op;
    } req_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              trc_valid = 1'b0;
    logic              trc_ready;
    logic [ADDR_W-1:0] trc_addr = '0;
    logic [OP_W-1:0]   trc_op = '0;
    logic              trc_last = 1'b0;
    logic              cache_req_valid;
    logic              cache_req_ready = 1'b0;
    logic [ADDR_W-1:0] cache_addr;
    logic [OP_W-1:0]   cache_op;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  issued_cnt;
    logic [CNT_W-1:0]  illegal_cnt;

    req_t             exp_q[$];
    req_t             mon_r;
    req_t             got_r;
    logic [CNT_W-1:0] exp_issued = '0;
    logic [CNT_W-1:0] exp_illegal = '0;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    cache_trace_feeder #(
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .trc_valid       (trc_valid),
        .trc_ready       (trc_ready),
        .trc_addr        (trc_addr),
        .trc_op          (trc_op),
        .trc_last        (trc_last),
        .cache_req_valid (cache_req_valid),
        .cache_req_ready (cache_req_ready),
        .cache_addr      (cache_addr),
        .cache_op        (cache_op),
        .busy            (busy),
        .done            (done),
        .issued_cnt      (issued_cnt),
        .illegal_cnt     (illegal_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: legal accepted beats are queued, each cache handshake pops one.
    always @(negedge clk) begin
        if (reset) begin
            if (trc_valid && trc_ready) begin
                if (trc_op == 8'h52 || trc_op == 8'h57) begin
                    mon_r.addr = trc_addr;
                    mon_r.op   = trc_op;
                    exp_q.push_back(mon_r);
                end else if (exp_illegal != CMAX) begin
                    exp_illegal++;
                end
            end
            if (cache_req_valid)
                chk("op_legal", (cache_op == 8'h52 || cache_op == 8'h57), 1);
            if (cache_req_valid && cache_req_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", cache_req_valid, 0);
                end else begin
                    got_r = exp_q.pop_front();
                    chk("req_addr", cache_addr, got_r.addr);
                    chk("req_op", cache_op, got_r.op);
                end
                if (exp_issued != CMAX) exp_issued++;
            end
        end
    end

    task automatic do_reset(input string tag);
        reset = 1'b0;
        exp_q.delete();
        exp_issued  = '0;
        exp_illegal = '0;
        #1;
        chk({tag, "_rst_req_valid"}, cache_req_valid, 0);
        chk({tag, "_rst_trc_ready"}, trc_ready, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_issued"}, issued_cnt, 0);
        chk({tag, "_rst_illegal"}, illegal_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic beat(input logic [47:0] a, input logic [7:0] op, input logic last);
        bit acc = 1'b0;
        trc_valid = 1'b1;
        trc_addr  = a;
        trc_op    = op;
        trc_last  = last;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clk);
            acc = trc_ready;
            @(posedge clk); #1;
        end
        trc_valid = 1'b0;
        trc_last  = 1'b0;
        chk("beat_accept", acc, 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        chk({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef CACHE_FEEDER_STATS_EN
        chk({tag, "_issued"}, issued_cnt, exp_issued);
        chk({tag, "_illegal"}, illegal_cnt, exp_illegal);
`else
        chk({tag, "_issued"}, issued_cnt, 0);
        chk({tag, "_illegal"}, illegal_cnt, 0);
`endif
    endtask

    initial begin
        bit got10;

        // Reset state
        @(posedge clk); #1;
        do_reset("t0");
        chk("t0_rst_addr", cache_addr, 0);
        chk("t0_rst_op", cache_op, 0);
        @(negedge clk);
        chk("t0_post_trc_ready", trc_ready, 1);
        @(posedge clk); #1;

        // Reset mid-trace discards pending beats
        for (int i = 0; i < 5; i++) beat(48'h1000 + 48'(i), 8'h52, 1'b0);
        chk("t1_busy", busy, 1);
        do_reset("t1");
        @(negedge clk);
        chk("t1_trc_ready", trc_ready, 1);
        chk("t1_busy_after", busy, 0);
        cache_req_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("t1_no_req", cache_req_valid, 0);
        @(posedge clk); #1;

        // Single beat latency and done pulse
        beat(48'h7fff493822b8, 8'h57, 1'b1);
        chk("t2_lat_k", cache_req_valid, 0);
        @(negedge clk);
        chk("t2_lat_k_neg", cache_req_valid, 0);
        @(posedge clk); #1;
        chk("t2_lat_k1", cache_req_valid, 1);
        chk("t2_addr", cache_addr, 48'h7fff493822b8);
        chk("t2_op", cache_op, 8'h57);
        wait_done("t2");
        chk_cnt("t2");
`ifdef CACHE_FEEDER_STATS_EN
        chk("t2_issued_one", issued_cnt, 1);
`endif

        // Back-pressure: 9 beats fill FIFO plus output register
        cache_req_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            beat(48'h30000000 + 48'(i), (i % 2) ? 8'h57 : 8'h52, 1'b0);
        @(negedge clk);
        chk("t3_ready_low", trc_ready, 0);
        chk("t3_head_addr", cache_addr, 48'h30000000);
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_addr", cache_addr, 48'h30000000);
            chk("t3_hold_op", cache_op, 8'h52);
            chk("t3_hold_vld", cache_req_valid, 1);
            chk("t3_hold_ready", trc_ready, 0);
        end
        @(posedge clk); #1;
        trc_valid = 1'b1;
        trc_addr  = 48'h30000009;
        trc_op    = 8'h57;
        trc_last  = 1'b1;
        cache_req_ready = 1'b1;
        got10 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            @(negedge clk);
            chk("t3_stream_vld", cache_req_valid, 1);
            acc = trc_valid && trc_ready;
            @(posedge clk); #1;
            if (acc) begin
                got10 = 1'b1;
                trc_valid = 1'b0;
                trc_last  = 1'b0;
            end
        end
        trc_valid = 1'b0;
        chk("t3_beat10_acc", got10, 1);
        wait_done("t3");
        chk_cnt("t3");

        // Illegal op between two reads
        beat(48'h40000001, 8'h52, 1'b0);
        beat(48'h40000002, 8'h41, 1'b0);
        beat(48'h40000003, 8'h52, 1'b1);
        wait_done("t4");
        chk_cnt("t4");

        // Illegal op carrying trc_last still closes the trace
        beat(48'h50000001, 8'h57, 1'b0);
        beat(48'h50000002, 8'h52, 1'b0);
        beat(48'h50000003, 8'h5a, 1'b1);
        wait_done("t5");
        chk_cnt("t5");

        // Saturation with CNT_W=4
        do_reset("t6");
        cache_req_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            beat(48'h60000000 + 48'(i), 8'h52, (i == 19));
        wait_done("t6");
        chk_cnt("t6");
`ifdef CACHE_FEEDER_STATS_EN
        chk("t6_sat", issued_cnt, 15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
